pwm_seq_ctrl: RTL and testbench
===============================

// Module: pwm_seq_ctrl
// PURPOSE
//  Duty-cycle sequencer for one pwm_basico-style PWM channel. Stores a
//  programmable table of (duty, hold) steps and plays them out in order.
//  Updates the duty output only on PWM period boundaries (period_end), so the
//  waveform never glitches. It replaces a hard-coded duty pattern with a
//  runtime-loaded one. Its duty output drives the PWM comparator's duty input.
// PARAMETERS
//  R     5  duty width; the PWM counter width (period = 2**R counts)
//  DEPTH 8  number of table entries
//  AW    3  table address width, clog2(DEPTH)
//  HW    4  hold-count width; an entry lasts hold+1 PWM periods
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset
//  period_end in   1   1-cycle pulse from PWM counter when it wraps 2**R-1 -> 0
//  start      in   1   pulse: begin sequence at entry 0
//  stop       in   1   pulse: abort sequence at next period boundary
//  loop_en    in   1   1 = wrap to entry 0 after last_idx; sampled at start
//  last_idx   in   AW  index of final entry; sampled at start
//  wr_en      in   1   table write strobe
//  wr_addr    in   AW  table write address
//  wr_duty    in   R   duty value to write
//  wr_hold    in   HW  hold count to write
//  duty       out  R   current duty to PWM comparator (registered)
//  step_idx   out  AW  index of entry currently playing
//  busy       out  1   high in ARM and RUN
//  done       out  1   1-cycle pulse on normal (non-looping) completion
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, duty=0, step_idx=0, busy=0, done=0.
//   hold_cnt=0, stop_pend=0. All table entries cleared to (0,0).
//   Reset mid-sequence aborts immediately; no done pulse is issued.
//  FSM: IDLE -> ARM -> RUN -> IDLE.
//   IDLE: duty=0. On start (with no stop in the same cycle) -> ARM.
//    At that transition, latch loop_en and last_idx; clamp last_idx to DEPTH-1.
//    Clear step_idx to 0.
//   ARM: wait for period_end. On it: duty<=tbl[0].duty, hold_cnt<=tbl[0].hold -> RUN.
//   RUN, on each period_end:
//    If stop_pend: duty<=0, step_idx<=0 -> IDLE; no done pulse.
//    Else if hold_cnt!=0: hold_cnt<=hold_cnt-1.
//    Else if step_idx!=last_idx: step_idx+1; load that entry's duty and hold.
//    Else if loop_en: step_idx<=0; load entry 0.
//    Else: duty<=0, step_idx<=0 -> IDLE; done=1 in the next cycle.
//  Between period_end pulses, duty is held constant in all states.
//  stop: sets stop_pend in ARM/RUN. stop_pend clears on entry to IDLE.
//   stop in IDLE is ignored. A stop in ARM exits to IDLE at the next period_end.
//   stop takes priority over a start or advance in the same cycle.
//  start while busy=1 is ignored.
//  Table writes are accepted in any state. wr_addr >= DEPTH is ignored.
//   Loads read before write: a same-cycle write to the entry being loaded
//   yields the old value. The new value is used on the next load of that entry.
//  period_end in the same cycle as start is not seen by ARM; ARM waits for the next one.
// CONFIGURATION
//  PWM_SEQ_RAMP_EN defined:
//   On a load, the target is set, but duty moves by +/-1 LSB per period_end
//   toward it. The hold countdown starts only once duty==target.
//   stop still forces duty<=0 immediately at the boundary.
//  PWM_SEQ_RAMP_EN undefined: duty jumps directly to the target on load.
// TESTING
//  1 Reset: reset=0 mid-RUN -> duty=0, busy=0, step_idx=0, done=0 immediately.
//  2 Table {0:(24,0),1:(31,1),2:(8,0)}, last_idx=2, loop_en=0, period_end
//    every 32 clk, start -> duty=0 until 1st period_end.
//    Then 24 for 1 period, 31 for 2 periods, 8 for 1 period, then 0.
//    done pulses once; busy=0.
//  3 Same table, loop_en=1 -> after entry 2, duty=24, step_idx=0, no done.
//    Runs 3 full loops identically.
//  4 stop during entry 1 -> duty stays 31 until next period_end, then 0.
//    busy=0, done never pulses.
//  5 Write (5,0) to entry 1 while entry 1 plays with loop_en=1 -> current
//    step unaffected; next pass plays 5. Write to wr_addr=7 with last_idx=2
//    has no visible effect.
//  6 PWM_SEQ_RAMP_EN, entry0=(4,1) from IDLE -> duty 1,2,3,4 on successive
//    period_ends, then 4 held 2 more periods before advancing.

Source files
------------

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: plays a runtime-loaded table of (duty, hold) steps, changing duty only on PWM period boundaries.
// Define PWM_SEQ_RAMP_EN to slew duty by one LSB per period toward each loaded target.
module pwm_seq_ctrl #(
    parameter int R     = 5,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int HW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          period_end_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_en_i,
    input  logic [AW-1:0] last_idx_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [R-1:0]  wr_duty_i,
    input  logic [HW-1:0] wr_hold_i,
    output logic [R-1:0]  duty_o,
    output logic [AW-1:0] step_idx_o,
    output logic          busy_o,
    output logic          done_o
);
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;
    state_e        state_q, state_d;
    logic [R-1:0]  duty_q, duty_d;
    logic [AW-1:0] step_q, step_d, last_q, last_d, ld_idx;
    logic [HW-1:0] hold_q, hold_d;
    logic          stop_q, stop_d, loop_q, loop_d, done_q, done_d, ld, fin;
    logic [R-1:0]  tbl_duty_q [DEPTH];
    logic [HW-1:0] tbl_hold_q [DEPTH];
`ifdef PWM_SEQ_RAMP_EN
    logic [R-1:0]  tgt_q, tgt_d;
    function automatic logic [R-1:0] toward(input logic [R-1:0] a, input logic [R-1:0] b);
        return (a < b) ? a + R'(1) : (a > b) ? a - R'(1) : a;
    endfunction
`endif
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        step_d  = step_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        last_d  = last_q;
        stop_d  = stop_q | (stop_i && state_q != IDLE);
        done_d  = 1'b0;
        ld      = 1'b0;
        ld_idx  = '0;
        fin     = 1'b0;
`ifdef PWM_SEQ_RAMP_EN
        tgt_d   = tgt_q;
`endif
        case (state_q)
            IDLE: if (start_i && !stop_i) begin
                state_d = ARM;
                loop_d  = loop_en_i;
                last_d  = (int'(last_idx_i) > DEPTH - 1) ? AW'(DEPTH - 1) : last_idx_i;
                step_d  = '0;
            end
            ARM: if (period_end_i) begin
                if (stop_d) fin = 1'b1;
                else begin
                    state_d = RUN;
                    ld      = 1'b1;
                end
            end
            RUN: if (period_end_i) begin
                if (stop_d) fin = 1'b1;
`ifdef PWM_SEQ_RAMP_EN
                else if (duty_q != tgt_q) duty_d = toward(duty_q, tgt_q);
`endif
                else if (hold_q != '0) hold_d = hold_q - HW'(1);
                else if (step_q != last_q) begin
                    ld     = 1'b1;
                    ld_idx = step_q + AW'(1);
                end
                else if (loop_q) ld = 1'b1;
                else begin
                    fin    = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Table is read from the registered copy, so a same-cycle write is not seen
        if (ld) begin
            step_d = ld_idx;
            hold_d = tbl_hold_q[ld_idx];
`ifdef PWM_SEQ_RAMP_EN
            tgt_d  = tbl_duty_q[ld_idx];
            duty_d = toward(duty_q, tbl_duty_q[ld_idx]);
`else
            duty_d = tbl_duty_q[ld_idx];
`endif
        end
        if (fin) begin
            state_d = IDLE;
            duty_d  = '0;
            step_d  = '0;
            stop_d  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
            tgt_q   <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                tbl_duty_q[i] <= '0;
                tbl_hold_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
`ifdef PWM_SEQ_RAMP_EN
            tgt_q   <= tgt_d;
`endif
            if (wr_en_i && int'(wr_addr_i) < DEPTH) begin
                tbl_duty_q[wr_addr_i] <= wr_duty_i;
                tbl_hold_q[wr_addr_i] <= wr_hold_i;
            end
        end
    end
    assign duty_o     = duty_q;
    assign step_idx_o = step_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: directed and randomized checks of pwm_seq_ctrl against a period-level queue model.
module tb_pwm_seq_ctrl;
    localparam int R = 5, DEPTH = 8, AW = 3, HW = 4;
    logic          clk = 1'b0, reset = 1'b0;
    logic          period_end = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] last_idx = '0, wr_addr = '0;
    logic [R-1:0]  wr_duty = '0;
    logic [HW-1:0] wr_hold = '0;
    logic [R-1:0]  duty;
    logic [AW-1:0] step_idx;
    logic          busy, done;

    pwm_seq_ctrl #(.R(R), .DEPTH(DEPTH), .AW(AW), .HW(HW)) dut (
        .clk(clk), .reset(reset), .period_end_i(period_end), .start_i(start), .stop_i(stop),
        .loop_en_i(loop_en), .last_idx_i(last_idx), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_duty_i(wr_duty), .wr_hold_i(wr_hold), .duty_o(duty), .step_idx_o(step_idx),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, done_seen = 0, per = 32, pe_cnt = 0;
    // Model: each playing entry expands into a queue of per-period duty values
    int  m_duty, m_idx, m_last;
    bit  m_busy, m_armed, m_stop, m_loop, m_done;
    int  q[$];
    int  t_duty[DEPTH], t_hold[DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go_idle();
        m_busy = 0; m_armed = 0; m_stop = 0; m_duty = 0; m_idx = 0;
        q.delete();
    endtask

    task automatic model_reset();
        go_idle();
        m_done = 0;
        for (int i = 0; i < DEPTH; i++) begin
            t_duty[i] = 0;
            t_hold[i] = 0;
        end
    endtask

    task automatic fetch(input int i);
`ifdef PWM_SEQ_RAMP_EN
        int d;
        d = m_duty;
        while (d != t_duty[i]) begin
            d += (t_duty[i] > d) ? 1 : -1;
            if (d != t_duty[i]) q.push_back(d);
        end
`endif
        m_idx = i;
        repeat (t_hold[i] + 1) q.push_back(t_duty[i]);
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!m_busy) begin
            if (start && !stop) begin
                m_busy = 1; m_armed = 1; m_loop = loop_en; m_last = int'(last_idx); m_idx = 0;
            end
        end else begin
            if (stop) m_stop = 1;
            if (period_end) begin
                if (m_stop) go_idle();
                else begin
                    if (q.size() == 0) begin
                        if (m_armed) begin
                            m_armed = 0;
                            fetch(0);
                        end
                        else if (m_idx < m_last) fetch(m_idx + 1);
                        else if (m_loop) fetch(0);
                        else begin
                            go_idle();
                            m_done = 1;
                        end
                    end
                    if (m_busy) m_duty = q.pop_front();
                end
            end
        end
        if (wr_en) begin
            t_duty[wr_addr] = int'(wr_duty);
            t_hold[wr_addr] = int'(wr_hold);
        end
    endtask

    task automatic tick();
        period_end = (pe_cnt == per - 1);
        @(posedge clk);
        model_edge();
        pe_cnt = (pe_cnt + 1) % per;
        #1;
        check("duty", 32'(duty), m_duty);
        check("step_idx", 32'(step_idx), m_idx);
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        if (done) done_seen++;
        start = 0; stop = 0; wr_en = 0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input int a, input int d, input int h);
        wr_en = 1; wr_addr = AW'(a); wr_duty = R'(d); wr_hold = HW'(h);
        tick();
    endtask

    task automatic go(input int last, input bit lp);
        start = 1; last_idx = AW'(last); loop_en = lp;
        tick();
    endtask

    task automatic wait_step(input int s, input string tag);
        for (int i = 0; i < 400 && int'(step_idx) != s; i++) tick();
        check(tag, 32'(step_idx), s);
    endtask

    task automatic async_reset();
        reset = 0;
        #1;
        model_reset();
        check("rst_duty", 32'(duty), 0);
        check("rst_step", 32'(step_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_duty", 32'(duty), 0);
        check("init_step", 32'(step_idx), 0);
        check("init_busy", 32'(busy), 0);
        check("init_done", 32'(done), 0);
        @(negedge clk);
        reset = 1;
        // Single pass: 24 x1, 31 x2, 8 x1, then 0 with one done
        write(0, 24, 0); write(1, 31, 1); write(2, 8, 0);
        done_seen = 0;
        go(2, 0);
        run(32 * 6);
        check("t2_done_count", done_seen, 1);
        check("t2_busy", 32'(busy), 0);
        // Looping: three full passes, no done
        done_seen = 0;
        go(2, 1);
        run(32 * 13);
        check("t3_done_count", done_seen, 0);
        check("t3_busy", 32'(busy), 1);
        // Stop during entry 1
        wait_step(1, "t4_reach_e1");
        stop = 1;
        tick();
        run(64);
        check("t4_busy", 32'(busy), 0);
        check("t4_done_count", done_seen, 0);
        // Rewrite the playing entry; write beyond last_idx
        go(2, 1);
        wait_step(1, "t5_reach_e1");
        write(1, 5, 0);
        write(7, 3, 2);
        run(32 * 10);
        stop = 1;
        tick();
        run(40);
        // Async reset mid-run
        write(1, 31, 1);
        go(2, 1);
        run(100);
        check("t1_busy_before", 32'(busy), 1);
        async_reset();
        run(40);
`ifdef PWM_SEQ_RAMP_EN
        write(0, 4, 1);
        go(0, 0);
        run(32 * 8);
`endif
        for (int s = 0; s < 40; s++) begin
            per = $urandom_range(2, 9);
            pe_cnt = 0;
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 99) < 6) begin
                    start = 1; last_idx = AW'($urandom); loop_en = 1'($urandom);
                end
                if ($urandom_range(0, 99) < 2) stop = 1;
                if ($urandom_range(0, 9) == 0) begin
                    wr_en = 1; wr_addr = AW'($urandom); wr_duty = R'($urandom); wr_hold = HW'($urandom_range(0, 3));
                end
                tick();
            end
            if (s % 10 == 9) async_reset();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
